// File: rtl/tt3_sweep_char.sv
// tt3_sweep_char: truth-table characterizer for 3-input logic stages.
// Walks {in1,in2,in3} through 000..111, holds each vector for SETTLE_CYCLES,
// captures the synchronized gate output into an 8-bit code (bit 7 = row 000)
// and compares the finished code against EXPECTED.
//
// The settle counter runs 0..SETTLE_CYCLES-1 within each vector.
// Phase SETTLE_CYCLES-2 is the capture edge, one cycle before the vector
// changes. At that point the synchronizer has had two cycles to carry the
// current vector's response. Phase SETTLE_CYCLES-1 advances to the next vector.
// The last vector finishes on its capture edge, so done appears one cycle
// before a ninth vector would have started.
module tt3_sweep_char #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [7:0]  EXPECTED      = 8'hC4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       dut_out,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  output logic [7:0] truth_table,
  output logic       match
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_t;

  localparam logic [15:0] CAPTURE_PHASE = 16'(SETTLE_CYCLES - 2);
  localparam logic [15:0] LAST_PHASE    = 16'(SETTLE_CYCLES - 1);

  state_t      state;
  logic [2:0]  idx;
  logic [15:0] settle_cnt;
  logic [2:0]  vec;
  logic        sync_q1;
  logic        s_out;
  logic [7:0]  tt_next;

  assign in1 = vec[2];
  assign in2 = vec[1];
  assign in3 = vec[0];

  // Two-flop synchronizer for the asynchronous gate output, running in every state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      s_out   <= 1'b0;
    end else begin
      sync_q1 <= dut_out;
      s_out   <= sync_q1;
    end
  end

  // Word as it will look once the current vector's bit has been written
  always_comb begin
    tt_next = truth_table;
    tt_next[3'd7 - idx] = s_out;
  end

  // Sweep sequencer: vector stepping, capture, completion and abort handling
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= 3'd0;
      settle_cnt  <= 16'd0;
      vec         <= 3'b000;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      truth_table <= 8'h00;
      match       <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            idx         <= 3'd0;
            settle_cnt  <= 16'd0;
            vec         <= 3'b000;
            truth_table <= 8'h00;
            match       <= 1'b0;
            busy        <= 1'b1;
            state       <= SETTLE;
          end
        end
        SETTLE: begin
          if (abort) begin
            aborted    <= 1'b1;
            busy       <= 1'b0;
            vec        <= 3'b000;
            idx        <= 3'd0;
            settle_cnt <= 16'd0;
            state      <= IDLE;
          end else if (settle_cnt == CAPTURE_PHASE) begin
            truth_table <= tt_next;
            if (idx == 3'd7) begin
              done       <= 1'b1;
              match      <= (tt_next == EXPECTED);
              busy       <= 1'b0;
              vec        <= 3'b000;
              idx        <= 3'd0;
              settle_cnt <= 16'd0;
              state      <= IDLE;
            end else begin
              settle_cnt <= settle_cnt + 16'd1;
            end
          end else if (settle_cnt == LAST_PHASE) begin
            settle_cnt <= 16'd0;
            idx        <= idx + 3'd1;
            vec        <= idx + 3'd1;
          end else begin
            settle_cnt <= settle_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
